// File: rtl/rtlmem_cnt_rmw_pkg.sv
// Shared types for the counter read-modify-write engine: op codes and FSM states.
package rtlmem_cnt_rmw_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_RD    = 2'b01,
    OP_RDCLR = 2'b10,
    OP_RSV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_RD   = 2'b10,
    ST_WR   = 2'b11
  } state_e;

endpackage

// File: rtl/rtlmem_cnt_rmw.sv
// Counter statistics engine: read-modify-write on memory port A, one op per two cycles.
// state | meaning
// INIT  | memory clearing or not ready; no requests accepted
// IDLE  | ready, waiting for a request
// RD    | read issued for the latched index
// WR    | read data back; write-back/response; may accept the next op
module rtlmem_cnt_rmw
  import rtlmem_cnt_rmw_pkg::*;
#(
  parameter int G_ADDR  = 10,
  parameter int G_WIDTH = 32,
  parameter int G_DELTA = 16,
  parameter int G_SAT   = 1
) (
  input  logic               clk_a,
  input  logic               rst_n,
  input  logic               mem_clrrdy,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic [1:0]         req_op,
  input  logic [G_ADDR-1:0]  req_idx,
  input  logic [G_DELTA-1:0] req_dlt,
  output logic               rsp_vld,
  output logic [G_WIDTH-1:0] rsp_dat,
  output logic               ovf,
  output logic [G_ADDR-1:0]  memad_a,
  output logic               memre_a,
  output logic               memwe_a,
  output logic [G_WIDTH-1:0] memdi_a,
  input  logic [G_WIDTH-1:0] memdo_a
);

  state_e             state;
  op_e                op_q;
  logic [G_ADDR-1:0]  idx_q;
  logic [G_DELTA-1:0] dlt_q;
  logic [G_WIDTH:0]   add_res;
  logic               live;
  logic               in_wr;

  // MSB of the result is the carry out, kept even when the low bits saturate
  function automatic logic [G_WIDTH:0] add_sat(input logic [G_WIDTH-1:0] a,
                                               input logic [G_DELTA-1:0] d);
    logic [G_WIDTH:0] sum;
    sum = {1'b0, a} + (G_WIDTH+1)'(d);
    if (G_SAT != 0 && sum[G_WIDTH]) sum[G_WIDTH-1:0] = '1;
    return sum;
  endfunction

  assign add_res = add_sat(memdo_a, dlt_q);
  assign live    = rst_n & mem_clrrdy;
  assign in_wr   = (state == ST_WR);

  // A write still in WR when clrrdy or reset drops must not reach the memory
  assign memre_a = (state == ST_RD);
  assign memwe_a = in_wr & live & ((op_q == OP_ADD) | (op_q == OP_RDCLR));
  assign memad_a = (state == ST_RD || state == ST_WR) ? idx_q : '0;
  assign memdi_a = (op_q == OP_ADD) ? add_res[G_WIDTH-1:0] : '0;
  assign ovf     = in_wr & live & (op_q == OP_ADD) & add_res[G_WIDTH];

  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      req_rdy <= 1'b0;
      rsp_vld <= 1'b0;
      rsp_dat <= '0;
      op_q    <= OP_ADD;
      idx_q   <= '0;
      dlt_q   <= '0;
    end else begin
      rsp_vld <= 1'b0;
      if (!mem_clrrdy) begin
        state   <= ST_INIT;
        req_rdy <= 1'b0;
      end else begin
        case (state)
          ST_INIT: begin
            state   <= ST_IDLE;
            req_rdy <= 1'b1;
          end
          ST_RD: begin
            state   <= ST_WR;
            req_rdy <= 1'b1;
          end
          default: begin
            if (state == ST_WR && op_q != OP_ADD) begin
              rsp_vld <= 1'b1;
              rsp_dat <= memdo_a;
            end
            if (req_vld && req_rdy) begin
              op_q    <= op_e'(req_op);
              idx_q   <= req_idx;
              dlt_q   <= req_dlt;
              state   <= ST_RD;
              req_rdy <= 1'b0;
            end else begin
              state   <= ST_IDLE;
              req_rdy <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
